// File: rtl/srio_pkg.sv
// Shared constants, FSM state encoding and ID-compare helper for the SRIO RX filter.
package srio_pkg;

  localparam logic [3:0]  FTYPE_SWRITE = 4'h6;
  localparam int unsigned FTYPE_MSB    = 55;
  localparam int unsigned FTYPE_LSB    = 52;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_PASS  = 2'd1,
    ST_DROP  = 2'd2,
    ST_TRUNC = 2'd3
  } filt_state_e;

  function automatic logic dest_match(input logic [15:0] dest,
                                      input logic [15:0] id,
                                      input logic [15:0] mask);
    return ((dest ^ id) & mask) == '0;
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry AXI-Stream skid buffer: registered output, registered upstream ready,
// one-cycle latency and full throughput while the sink is ready.
module axis_skid_buf #(
  parameter int unsigned DATA_W = 97
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              s_valid_i,
  output logic              s_ready_o,
  input  logic [DATA_W-1:0] s_data_i,
  output logic              m_valid_o,
  input  logic              m_ready_i,
  output logic [DATA_W-1:0] m_data_o
);

  logic              out_valid_q, out_valid_d;
  logic [DATA_W-1:0] out_data_q,  out_data_d;
  logic              skid_valid_q, skid_valid_d;
  logic [DATA_W-1:0] skid_data_q,  skid_data_d;
  logic              accept, pop;

  always_comb begin
    out_valid_d  = out_valid_q;
    out_data_d   = out_data_q;
    skid_valid_d = skid_valid_q;
    skid_data_d  = skid_data_q;
    accept       = s_valid_i && !skid_valid_q;
    pop          = !out_valid_q || m_ready_i;
    if (pop) begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_data_d   = skid_data_q;
        skid_valid_d = 1'b0;
      end else begin
        out_valid_d = accept;
        if (accept) out_data_d = s_data_i;
      end
    end else if (accept) begin
      // Output stalled: park the in-flight beat so ready can drop a cycle late.
      skid_valid_d = 1'b1;
      skid_data_d  = s_data_i;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      out_valid_q  <= 1'b0;
      out_data_q   <= '0;
      skid_valid_q <= 1'b0;
      skid_data_q  <= '0;
    end else begin
      out_valid_q  <= out_valid_d;
      out_data_q   <= out_data_d;
      skid_valid_q <= skid_valid_d;
      skid_data_q  <= skid_data_d;
    end
  end

  assign s_ready_o = !skid_valid_q;
  assign m_valid_o = out_valid_q;
  assign m_data_o  = out_data_q;

endmodule

// File: rtl/srio_rx_pkt_filter.sv
// SRIO RX packet filter: forwards SWRITE packets addressed to this endpoint, drops the rest.
// Build option: define SRIO_FILT_LEN_CHK_EN to truncate packets longer than MAX_BEATS.
module srio_rx_pkt_filter
  import srio_pkg::*;
#(
  parameter int unsigned MAX_BEATS = 33,
  parameter int unsigned CNT_W     = 32
) (
  input  logic             AXIS_ACLK,
  input  logic             AXIS_ARESET,
  input  logic             cfg_enable,
  input  logic [15:0]      cfg_dest_id,
  input  logic [15:0]      cfg_dest_mask,
  input  logic             cfg_clr_cnt,
  input  logic             S_AXIS_TVALID,
  output logic             S_AXIS_TREADY,
  input  logic [63:0]      S_AXIS_TDATA,
  input  logic             S_AXIS_TLAST,
  input  logic [31:0]      S_AXIS_TUSER,
  output logic             M_AXIS_TVALID,
  input  logic             M_AXIS_TREADY,
  output logic [63:0]      M_AXIS_TDATA,
  output logic             M_AXIS_TLAST,
  output logic [31:0]      M_AXIS_TUSER,
  output logic [CNT_W-1:0] pkt_pass_cnt,
  output logic [CNT_W-1:0] pkt_drop_cnt,
  output logic [15:0]      pkt_trunc_cnt
);

  if (MAX_BEATS < 2) begin : g_bad_max_beats
    $error("MAX_BEATS must be at least 2");
  end

  filt_state_e      state_q, state_d;
  logic             buf_ready, match, hs, fwd, force_last;
  logic             pass_inc, drop_inc, trunc_inc;
  logic [CNT_W-1:0] pass_q, pass_d, drop_q, drop_d;
  logic [96:0]      buf_in, buf_out;

  assign match = cfg_enable
              && (S_AXIS_TDATA[FTYPE_MSB:FTYPE_LSB] == FTYPE_SWRITE)
              && dest_match(S_AXIS_TUSER[15:0], cfg_dest_id, cfg_dest_mask);
  assign hs = S_AXIS_TVALID && S_AXIS_TREADY;

`ifdef SRIO_FILT_LEN_CHK_EN
  localparam int unsigned BEAT_W = $clog2(MAX_BEATS + 1);
  logic [BEAT_W-1:0] beat_q, beat_d;
  logic [15:0]       trunc_q, trunc_d;

  assign force_last = (state_q == ST_PASS) && !S_AXIS_TLAST
                   && (beat_q == BEAT_W'(MAX_BEATS - 1));

  always_comb begin
    beat_d  = beat_q;
    trunc_d = trunc_q;
    if (fwd) beat_d = (state_q == ST_IDLE) ? BEAT_W'(1) : beat_q + 1'b1;
    if (cfg_clr_cnt)                     trunc_d = '0;
    else if (trunc_inc && trunc_q != '1) trunc_d = trunc_q + 1'b1;
  end

  always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
    if (AXIS_ARESET) begin
      beat_q  <= '0;
      trunc_q <= '0;
    end else begin
      beat_q  <= beat_d;
      trunc_q <= trunc_d;
    end
  end

  assign pkt_trunc_cnt = trunc_q;
`else
  assign force_last    = 1'b0;
  assign pkt_trunc_cnt = '0;
`endif

  always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
    if (AXIS_ARESET) state_q <= ST_IDLE;
    else             state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:  if (hs && !S_AXIS_TLAST) state_d = match ? ST_PASS : ST_DROP;
      ST_PASS:  if (hs && S_AXIS_TLAST) state_d = ST_IDLE;
                else if (hs && force_last) state_d = ST_TRUNC;
      ST_DROP,
      ST_TRUNC: if (hs && S_AXIS_TLAST) state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
  end

  // Drop-side ready is unconditional; elsewhere it follows the buffer's registered ready.
  always_comb begin
    S_AXIS_TREADY = buf_ready;
    fwd           = 1'b0;
    drop_inc      = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        fwd      = hs && match;
        drop_inc = hs && !match && S_AXIS_TLAST;
      end
      ST_PASS:  fwd = hs;
      ST_DROP: begin
        S_AXIS_TREADY = 1'b1;
        drop_inc      = hs && S_AXIS_TLAST;
      end
      ST_TRUNC: S_AXIS_TREADY = 1'b1;
      default:  S_AXIS_TREADY = buf_ready;
    endcase
    pass_inc  = fwd && (S_AXIS_TLAST || force_last);
    trunc_inc = fwd && force_last;
  end

  always_comb begin
    pass_d = pass_q;
    drop_d = drop_q;
    if (cfg_clr_cnt) begin
      pass_d = '0;
      drop_d = '0;
    end else begin
      if (pass_inc && pass_q != '1) pass_d = pass_q + 1'b1;
      if (drop_inc && drop_q != '1) drop_d = drop_q + 1'b1;
    end
  end

  always_ff @(posedge AXIS_ACLK or posedge AXIS_ARESET) begin
    if (AXIS_ARESET) begin
      pass_q <= '0;
      drop_q <= '0;
    end else begin
      pass_q <= pass_d;
      drop_q <= drop_d;
    end
  end

  assign buf_in = {S_AXIS_TLAST || force_last, S_AXIS_TUSER, S_AXIS_TDATA};

  axis_skid_buf #(.DATA_W(97)) u_skid (
    .clk_i     (AXIS_ACLK),
    .rst_i     (AXIS_ARESET),
    .s_valid_i (fwd),
    .s_ready_o (buf_ready),
    .s_data_i  (buf_in),
    .m_valid_o (M_AXIS_TVALID),
    .m_ready_i (M_AXIS_TREADY),
    .m_data_o  (buf_out)
  );

  assign M_AXIS_TLAST  = buf_out[96];
  assign M_AXIS_TUSER  = buf_out[95:64];
  assign M_AXIS_TDATA  = buf_out[63:0];
  assign pkt_pass_cnt  = pass_q;
  assign pkt_drop_cnt  = drop_q;

endmodule

// File: tb/tb_srio_rx_pkt_filter.sv
// Directed self-checking bench for srio_rx_pkt_filter; truncation cases need SRIO_FILT_LEN_CHK_EN.
module tb_srio_rx_pkt_filter;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_enable = 1'b0;
  logic [15:0] cfg_dest_id = '0;
  logic [15:0] cfg_dest_mask = '0;
  logic        cfg_clr_cnt = 1'b0;
  logic        S_AXIS_TVALID = 1'b0;
  logic        S_AXIS_TREADY;
  logic [63:0] S_AXIS_TDATA = '0;
  logic        S_AXIS_TLAST = 1'b0;
  logic [31:0] S_AXIS_TUSER = '0;
  logic        M_AXIS_TVALID;
  logic        M_AXIS_TREADY = 1'b1;
  logic [63:0] M_AXIS_TDATA;
  logic        M_AXIS_TLAST;
  logic [31:0] M_AXIS_TUSER;
  logic [31:0] pkt_pass_cnt, pkt_drop_cnt;
  logic [15:0] pkt_trunc_cnt;

  int unsigned n_cmp = 0, n_err = 0;
  int unsigned cyc = 0, hs_cyc = 0, vld_cyc = 0, pkt_id = 1;
  bit          vld_seen = 0, stall_q = 0, tgl_mode = 0;
  logic [96:0] mbeat, hold_beat;
  logic [96:0] exp_q[$], got_q[$];
  int unsigned cyc_n;

  srio_rx_pkt_filter #(.MAX_BEATS(33), .CNT_W(32)) dut (
    .AXIS_ACLK     (clk),
    .AXIS_ARESET   (rst),
    .cfg_enable    (cfg_enable),
    .cfg_dest_id   (cfg_dest_id),
    .cfg_dest_mask (cfg_dest_mask),
    .cfg_clr_cnt   (cfg_clr_cnt),
    .S_AXIS_TVALID (S_AXIS_TVALID),
    .S_AXIS_TREADY (S_AXIS_TREADY),
    .S_AXIS_TDATA  (S_AXIS_TDATA),
    .S_AXIS_TLAST  (S_AXIS_TLAST),
    .S_AXIS_TUSER  (S_AXIS_TUSER),
    .M_AXIS_TVALID (M_AXIS_TVALID),
    .M_AXIS_TREADY (M_AXIS_TREADY),
    .M_AXIS_TDATA  (M_AXIS_TDATA),
    .M_AXIS_TLAST  (M_AXIS_TLAST),
    .M_AXIS_TUSER  (M_AXIS_TUSER),
    .pkt_pass_cnt  (pkt_pass_cnt),
    .pkt_drop_cnt  (pkt_drop_cnt),
    .pkt_trunc_cnt (pkt_trunc_cnt)
  );

  initial forever #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  assign mbeat = {M_AXIS_TLAST, M_AXIS_TUSER, M_AXIS_TDATA};

  task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Sink ready: held at 1, or toggling 1010... when tgl_mode is set.
  always @(posedge clk) begin
    #1;
    M_AXIS_TREADY = tgl_mode ? ~M_AXIS_TREADY : 1'b1;
  end

  always @(negedge clk) begin
    if (stall_q) check("m_hold", {M_AXIS_TVALID, mbeat}, {1'b1, hold_beat});
    if (M_AXIS_TVALID && !vld_seen) begin
      vld_seen = 1;
      vld_cyc  = cyc;
    end
    if (M_AXIS_TVALID && M_AXIS_TREADY) got_q.push_back(mbeat);
    stall_q   = M_AXIS_TVALID && !M_AXIS_TREADY;
    hold_beat = mbeat;
  end

  // Drives one packet; queues the beats expected downstream when pass is set.
  task automatic send_pkt(input int unsigned nb, input logic [3:0] ft, input logic [31:0] user,
                          input bit pass, input int unsigned trunc_at, input int unsigned dis_at,
                          input bit clr_last, output int unsigned cycles);
    logic [63:0] data;
    logic        last;
    bit          hs;
    int unsigned n;
    cycles = 0;
    for (int unsigned i = 0; i < nb; i++) begin
      data = (i == 0) ? {8'hA5, ft, 52'h1_2345_6789_ABCD} : {16'hBEEF, 16'(pkt_id), 32'(i)};
      last = (i == nb - 1);
      S_AXIS_TVALID = 1'b1;
      S_AXIS_TDATA  = data;
      S_AXIS_TUSER  = user;
      S_AXIS_TLAST  = last;
      if (dis_at != 0 && i == dis_at) cfg_enable = 1'b0;
      if (clr_last && last) cfg_clr_cnt = 1'b1;
      hs = 0;
      n  = 0;
      while (!hs && n < 200) begin
        @(negedge clk);
        hs = S_AXIS_TREADY;
        @(posedge clk);
        #1;
        n++;
      end
      cfg_clr_cnt = 1'b0;
      check("s_handshake", 128'(hs), 128'(1));
      if (i == 0) hs_cyc = cyc;
      cycles += n;
      if (pass && (trunc_at == 0 || i < trunc_at))
        exp_q.push_back({last || (i + 1 == trunc_at), user, data});
      if (!hs) break;
    end
    S_AXIS_TVALID = 1'b0;
    S_AXIS_TLAST  = 1'b0;
    pkt_id++;
  endtask

  task automatic drain(input string tag);
    int unsigned n = 0;
    while (got_q.size() < exp_q.size() && n < 400) begin
      @(negedge clk);
      n++;
    end
    repeat (3) @(negedge clk);
    check({tag, "_beats"}, 128'(got_q.size()), 128'(exp_q.size()));
    for (int unsigned i = 0; i < exp_q.size() && i < got_q.size(); i++)
      check($sformatf("%s_beat%0d", tag, i), 128'(got_q[i]), 128'(exp_q[i]));
    exp_q.delete();
    got_q.delete();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    repeat (3) @(negedge clk);
    check("rst_mvalid", 128'(M_AXIS_TVALID), 128'(0));
    check("rst_mlast",  128'(M_AXIS_TLAST),  128'(0));
    check("rst_mdata",  128'(M_AXIS_TDATA),  128'(0));
    check("rst_muser",  128'(M_AXIS_TUSER),  128'(0));
    check("rst_pass",   128'(pkt_pass_cnt),  128'(0));
    check("rst_drop",   128'(pkt_drop_cnt),  128'(0));
    check("rst_trunc",  128'(pkt_trunc_cnt), 128'(0));
    @(posedge clk);
    #1;
    rst = 1'b0;
    cfg_enable = 1'b1;
    cfg_dest_id = 16'h0012;
    cfg_dest_mask = 16'hFFFF;
    repeat (2) @(posedge clk);
    #1;

    // 1: matching SWRITE; output valid right after the accepting edge
    vld_seen = 0;
    send_pkt(4, 4'h6, 32'h0034_0012, 1, 0, 0, 0, cyc_n);
    check("t1_cycles", 128'(cyc_n), 128'(4));
    drain("t1");
    check("t1_latency", 128'(vld_cyc - hs_cyc), 128'(0));
    check("t1_pass", 128'(pkt_pass_cnt), 128'(1));
    check("t1_drop", 128'(pkt_drop_cnt), 128'(0));

    // 2: ID mismatch -> dropped, ready every beat, no output
    vld_seen = 0;
    send_pkt(4, 4'h6, 32'h0034_0013, 0, 0, 0, 0, cyc_n);
    check("t2_cycles", 128'(cyc_n), 128'(4));
    drain("t2");
    check("t2_no_mvalid", 128'(vld_seen), 128'(0));
    check("t2_drop", 128'(pkt_drop_cnt), 128'(1));
    check("t2_pass", 128'(pkt_pass_cnt), 128'(1));

    // 3: NWRITE dropped; masked ID passes; single-beat packets both ways
    send_pkt(3, 4'h5, 32'h0034_0012, 0, 0, 0, 0, cyc_n);
    drain("t3a");
    check("t3a_drop", 128'(pkt_drop_cnt), 128'(2));
    cfg_dest_mask = 16'hFF00;
    send_pkt(3, 4'h6, 32'h0000_00AB, 1, 0, 0, 0, cyc_n);
    drain("t3b");
    check("t3b_pass", 128'(pkt_pass_cnt), 128'(2));
    send_pkt(1, 4'h6, 32'h0000_00AB, 1, 0, 0, 0, cyc_n);
    drain("t3c");
    check("t3c_pass", 128'(pkt_pass_cnt), 128'(3));
    send_pkt(1, 4'h5, 32'h0000_00AB, 0, 0, 0, 0, cyc_n);
    drain("t3d");
    check("t3d_drop", 128'(pkt_drop_cnt), 128'(3));
    cfg_dest_mask = 16'hFFFF;

    // 4: 16-beat packet against a 1010... sink
    tgl_mode = 1;
    send_pkt(16, 4'h6, 32'h0055_0012, 1, 0, 0, 0, cyc_n);
    drain("t4");
    tgl_mode = 0;
    check("t4_pass", 128'(pkt_pass_cnt), 128'(4));

    // 5: disable mid-packet, then clear coincident with TLAST
    send_pkt(4, 4'h6, 32'h0066_0012, 1, 0, 1, 0, cyc_n);
    drain("t5a");
    check("t5a_pass", 128'(pkt_pass_cnt), 128'(5));
    send_pkt(2, 4'h6, 32'h0066_0012, 0, 0, 0, 0, cyc_n);
    drain("t5b");
    check("t5b_drop", 128'(pkt_drop_cnt), 128'(4));
    cfg_enable = 1'b1;
    send_pkt(3, 4'h6, 32'h0077_0012, 1, 0, 0, 1, cyc_n);
    drain("t5c");
    check("t5c_pass", 128'(pkt_pass_cnt), 128'(0));
    check("t5c_drop", 128'(pkt_drop_cnt), 128'(0));
    send_pkt(2, 4'h6, 32'h0077_0012, 1, 0, 0, 0, cyc_n);
    drain("t5d");
    check("t5d_pass", 128'(pkt_pass_cnt), 128'(1));

`ifdef SRIO_FILT_LEN_CHK_EN
    // 6: 40-beat packet cut at beat 33, then a normal packet
    send_pkt(40, 4'h6, 32'h0088_0012, 1, 33, 0, 0, cyc_n);
    drain("t6a");
    check("t6a_pass",  128'(pkt_pass_cnt),  128'(2));
    check("t6a_trunc", 128'(pkt_trunc_cnt), 128'(1));
    check("t6a_drop",  128'(pkt_drop_cnt),  128'(0));
    send_pkt(2, 4'h6, 32'h0088_0012, 1, 0, 0, 0, cyc_n);
    drain("t6b");
    check("t6b_pass",  128'(pkt_pass_cnt),  128'(3));
    check("t6b_trunc", 128'(pkt_trunc_cnt), 128'(1));
`else
    check("trunc_tied", 128'(pkt_trunc_cnt), 128'(0));
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
